// File: rtl/bounded_dsp_pkg.sv
// +------------------------------------------------------------------+
// | bounded_dsp_pkg                                                  |
// | Shared types and helpers for the bounded integrator and          |
// | bounded differentiator pair.                                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package bounded_dsp_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_t;

  // The running sum of SIZE WIDTH-bit samples needs ceil(log2(SIZE+1)) extra bits.
  function automatic int sum_width(input int width, input int size);
    return width + $clog2(size + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_delay_line.sv
// +------------------------------------------------------------------+
// | sample_delay_line                                                |
// | DEPTH-stage enabled shift register; o_tap is the oldest sample.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sample_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_tap
);

  generate
    if (DEPTH == 1) begin : g_single
      logic [WIDTH-1:0] r_tap;

      always_ff @(posedge clk) begin
        if (reset || i_clear) begin
          r_tap <= '0;
        end else if (i_en) begin
          r_tap <= i_din;
        end
      end

      assign o_tap = r_tap;
    end else begin : g_chain
      logic [WIDTH-1:0] r_line [DEPTH];

      always_ff @(posedge clk) begin
        if (reset || i_clear) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_line[i] <= '0;
          end
        end else if (i_en) begin
          r_line[0] <= i_din;
          for (int i = 1; i < DEPTH; i++) begin
            r_line[i] <= r_line[i-1];
          end
        end
      end

      assign o_tap = r_line[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/bounded_differentiator.sv
// +------------------------------------------------------------------+
// | bounded_differentiator                                           |
// | Recovers x[n] = y[n] - y[n-1] + x[n-SIZE] from a moving-sum      |
// | stream. Optional range checker: BOUNDED_DIFF_CHECK_EN.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bounded_differentiator
  import bounded_dsp_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int SIZE         = 5,
  parameter int LOG2_SIZE_P1 = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [WIDTH+LOG2_SIZE_P1-1:0] i_tdata,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [WIDTH-1:0]              o_tdata,
  output logic                          o_tvalid,
  input  logic                          o_tready,
  output logic                          o_primed,
  output logic                          o_error
);

  localparam int c_SUM_W = WIDTH + LOG2_SIZE_P1;
  localparam int c_CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SIZE - 1);

  fill_state_t        r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_count, w_count_nxt;
  logic [c_SUM_W-1:0] r_y_prev;
  logic [WIDTH-1:0]   r_data;
  logic               r_valid;
  logic [WIDTH-1:0]   w_tap;
  logic [c_SUM_W-1:0] w_sum;
  logic [WIDTH-1:0]   w_x;
  logic               w_accept;
  logic               w_flush;

  assign w_flush  = reset | clear;
  // Ready is withheld during a flush so a sample offered then is never taken.
  assign i_tready = (~r_valid | o_tready) & ~w_flush;
  assign w_accept = i_tvalid & i_tready;

  assign w_sum = i_tdata - r_y_prev + {{LOG2_SIZE_P1{w_tap[WIDTH-1]}}, w_tap};
  assign w_x   = w_sum[WIDTH-1:0];

  sample_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (SIZE)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .i_clear (clear),
    .i_en    (w_accept),
    .i_din   (w_x),
    .o_tap   (w_tap)
  );

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state <= FILL;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (w_accept && (r_state == FILL)) begin
      if (r_count == c_CNT_LAST) begin
        w_state_nxt = RUN;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_y_prev <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      r_y_prev <= i_tdata;
      r_data   <= w_x;
      r_valid  <= 1'b1;
    end else if (o_tready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_tdata  = r_data;
  assign o_tvalid = r_valid;
  assign o_primed = (r_state == RUN);

`ifdef BOUNDED_DIFF_CHECK_EN
  logic [LOG2_SIZE_P1:0] w_hi;
  logic                  w_out_of_range;
  logic                  r_error;

  // A recovered value that does not fit signed WIDTH bits means the link lost sync.
  assign w_hi           = w_sum[c_SUM_W-1:WIDTH-1];
  assign w_out_of_range = ~(&w_hi) & (|w_hi);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_error <= 1'b0;
    end else if (w_accept && w_out_of_range) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_sum[c_SUM_W-1:WIDTH];
  assign o_error     = 1'b0;
`endif

endmodule

`default_nettype wire
